// File: rtl/fcmd_rx_decoder.sv
// fcmd_rx_decoder
// Receive side of the off-chip fast-command link into the DTU. One command
// bit arrives per DCLK_1 cycle, MSB of each 8-bit word first. The block finds
// word alignment from the IDLE codeword (8'h5A) and declares lock after
// LOCK_CNT aligned IDLE words in a row. Once locked, it turns each aligned
// command word into a one-cycle cmd_valid strobe with a 3-bit cmd_code.
// Invalid words are counted in a saturating err_cnt. ERR_LIMIT invalid words
// in a row drop the link back to HUNT.
//
// Build option FCMD_TMR_EN: the control state (FSM state, bit_cnt,
// match_cnt, consec_err) is kept in three copies. Every copy reloads from the
// 2-of-3 voted next state, so a single upset copy is repaired on the next
// edge and the outputs do not change. The extra output tmr_err pulses for one
// cycle whenever the copies disagree. Without the macro there is one copy and
// no tmr_err port. The decoder behaves the same in both builds.
module fcmd_rx_decoder #(
  parameter int LOCK_CNT  = 4,   // aligned IDLE words needed for lock (2..15)
  parameter int ERR_LIMIT = 3,   // consecutive invalid words that break lock (1..15)
  parameter int ERR_W     = 8    // width of the saturating error counter
) (
  input  logic             DCLK_1,
  input  logic             RST,
  input  logic             fcmd_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             cmd_valid,
  output logic [2:0]       cmd_code,
  output logic [ERR_W-1:0] err_cnt
`ifdef FCMD_TMR_EN
  ,
  output logic             tmr_err
`endif
);

  // Codewords on the link
  localparam logic [7:0] IDLE_W       = 8'h5A;
  localparam logic [7:0] BC0_W        = 8'h33;
  localparam logic [7:0] RESYNC_W     = 8'h66;
  localparam logic [7:0] TEST_PULSE_W = 8'h99;
  localparam logic [7:0] ADC_CAL_W    = 8'hCC;
  localparam logic [7:0] DTU_SYNC_W   = 8'hA5;

  localparam logic [3:0]       LOCK_CNT_C  = 4'(LOCK_CNT);
  localparam logic [3:0]       ERR_LIMIT_C = 4'(ERR_LIMIT);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  // HUNT must encode as zero: a cleared state vector means "hunting".
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Packed control-state vector: {state[1:0], bit_cnt[2:0], match_cnt[3:0], consec_err[3:0]}
  localparam int ST_W = 13;

`ifdef FCMD_TMR_EN
  localparam int NCOPY = 3;
`else
  localparam int NCOPY = 1;
`endif

  // Serial input shift register
  logic [7:0]      sr_reg;

  // Control state: stored copies, voted view and next value
  logic [ST_W-1:0] copy_q [NCOPY];
  logic [ST_W-1:0] st_vote;
  logic [ST_W-1:0] st_next;

  state_t          state_v;
  state_t          state_next;
  logic [2:0]      bit_cnt_v;
  logic [2:0]      bit_cnt_next;
  logic [3:0]      match_cnt_v;
  logic [3:0]      match_cnt_next;
  logic [3:0]      consec_err_v;
  logic [3:0]      consec_err_next;

  // Word decode
  logic            boundary;
  logic            is_idle;
  logic            is_cmd;
  logic [2:0]      dec_code;

  // Registered outputs and their next values
  logic            cmd_valid_next;
  logic [2:0]      cmd_code_next;
  logic            err_inc;
  logic            cmd_valid_reg;
  logic [2:0]      cmd_code_reg;
  logic [ERR_W-1:0] err_cnt_reg;

  // Shift every bit in, whatever the FSM state, so HUNT can test every bit offset
  always_ff @(posedge DCLK_1) begin
    if (RST) begin
      sr_reg <= '0;
    end else begin
      sr_reg <= {sr_reg[6:0], fcmd_in};
    end
  end

  // Classify the current shift-register contents as IDLE, a command, or invalid
  always_comb begin
    is_idle  = (sr_reg == IDLE_W);
    is_cmd   = 1'b1;
    dec_code = 3'd0;
    case (sr_reg)
      BC0_W:        dec_code = 3'd1;
      RESYNC_W:     dec_code = 3'd2;
      TEST_PULSE_W: dec_code = 3'd3;
      ADC_CAL_W:    dec_code = 3'd4;
      DTU_SYNC_W:   dec_code = 3'd5;
      default:      is_cmd   = 1'b0;
    endcase
  end

  // Control-state copies. Each copy reloads from the same voted next state,
  // so one copy that disagrees is overwritten on the following edge.
  genvar gi;
  for (gi = 0; gi < NCOPY; gi++) begin : g_copy
    logic [ST_W-1:0] st_reg;

    // State register for this copy
    always_ff @(posedge DCLK_1) begin
      if (RST) begin
        st_reg <= '0;
      end else begin
        st_reg <= st_next;
      end
    end

    assign copy_q[gi] = st_reg;
  end

`ifdef FCMD_TMR_EN
  logic tmr_err_reg;

  // Bitwise 2-of-3 majority over the three copies
  always_comb begin
    st_vote = (copy_q[0] & copy_q[1]) | (copy_q[0] & copy_q[2]) | (copy_q[1] & copy_q[2]);
  end

  // Flag any disagreement between copies for one cycle
  always_ff @(posedge DCLK_1) begin
    if (RST) begin
      tmr_err_reg <= 1'b0;
    end else begin
      tmr_err_reg <= (copy_q[0] != copy_q[1]) || (copy_q[0] != copy_q[2]);
    end
  end

  assign tmr_err = tmr_err_reg;
`else
  assign st_vote = copy_q[0];
`endif

  // Split the voted vector into fields and pack the next state
  assign state_v      = state_t'(st_vote[12:11]);
  assign bit_cnt_v    = st_vote[10:8];
  assign match_cnt_v  = st_vote[7:4];
  assign consec_err_v = st_vote[3:0];
  assign st_next      = {state_next, bit_cnt_next, match_cnt_next, consec_err_next};

  // A boundary cycle is the one where the shift register holds a full aligned word
  assign boundary = (bit_cnt_v == 3'd7);

  // Next-state logic: alignment search, lock qualification and loss of lock
  always_comb begin
    state_next      = state_v;
    bit_cnt_next    = bit_cnt_v + 3'd1;
    match_cnt_next  = match_cnt_v;
    consec_err_next = consec_err_v;
    case (state_v)
      HUNT: begin
        // Any bit offset may be the word boundary here
        if (is_idle) begin
          state_next     = ALIGN;
          bit_cnt_next   = 3'd0;
          match_cnt_next = 4'd1;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_idle) begin
            match_cnt_next = match_cnt_v + 4'd1;
            if (match_cnt_v + 4'd1 == LOCK_CNT_C) begin
              state_next      = LOCKED;
              consec_err_next = 4'd0;
            end
          end else begin
            // Commands count as a failed alignment too
            state_next = HUNT;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (is_idle || is_cmd) begin
            consec_err_next = 4'd0;
          end else if (consec_err_v + 4'd1 == ERR_LIMIT_C) begin
            state_next      = HUNT;
            consec_err_next = 4'd0;
          end else begin
            consec_err_next = consec_err_v + 4'd1;
          end
        end
      end
      default: begin
        // Unreachable encoding: fall back to searching for alignment
        state_next      = HUNT;
        match_cnt_next  = 4'd0;
        consec_err_next = 4'd0;
      end
    endcase
  end

  // Output decode: command strobe and error increment, only on locked boundaries
  always_comb begin
    cmd_valid_next = 1'b0;
    cmd_code_next  = 3'd0;
    err_inc        = 1'b0;
    if (state_v == LOCKED && boundary) begin
      if (is_cmd) begin
        cmd_valid_next = 1'b1;
        cmd_code_next  = dec_code;
      end else if (!is_idle) begin
        err_inc = 1'b1;
      end
    end
  end

  // Register the strobe so it lands one edge after the word's last bit
  always_ff @(posedge DCLK_1) begin
    if (RST) begin
      cmd_valid_reg <= 1'b0;
      cmd_code_reg  <= 3'd0;
    end else begin
      cmd_valid_reg <= cmd_valid_next;
      cmd_code_reg  <= cmd_code_next;
    end
  end

  // Saturating invalid-word counter. A clear beats a simultaneous increment,
  // and loss of lock leaves the count alone.
  always_ff @(posedge DCLK_1) begin
    if (RST || err_clr) begin
      err_cnt_reg <= '0;
    end else if (err_inc && err_cnt_reg != ERR_MAX) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign locked    = (state_v == LOCKED);
  assign cmd_valid = cmd_valid_reg;
  assign cmd_code  = cmd_code_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_fcmd_rx_decoder.sv
// Bench for fcmd_rx_decoder. Two instances share the stimulus: one with the
// default ERR_W and one with ERR_W=2, so counter saturation shows up too.
// A word-level reference model predicts every output after every edge. It is
// backed by a bit-history array and uses the alignment phase as
// (edge - align_edge) mod 8. A table of words with their expected
// post-word outputs and some hand-written corner sequences add named checks.
module tb_fcmd_rx_decoder;

  localparam int LOCK_CNT  = 4;
  localparam int ERR_LIMIT = 3;

  logic       clk;
  logic       RST;
  logic       fcmd_in;
  logic       err_clr;
  logic       locked,  cmd_valid;
  logic [2:0] cmd_code;
  logic [7:0] err_cnt;
  logic       locked2, cmd_valid2;
  logic [2:0] cmd_code2;
  logic [1:0] err_cnt2;
`ifdef FCMD_TMR_EN
  logic       tmr_err, tmr_err2;
`endif

  fcmd_rx_decoder #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .ERR_W(8)) dut (
    .DCLK_1(clk), .RST(RST), .fcmd_in(fcmd_in), .err_clr(err_clr),
    .locked(locked), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .err_cnt(err_cnt)
`ifdef FCMD_TMR_EN
    , .tmr_err(tmr_err)
`endif
  );

  fcmd_rx_decoder #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .ERR_W(2)) dut2 (
    .DCLK_1(clk), .RST(RST), .fcmd_in(fcmd_in), .err_clr(err_clr),
    .locked(locked2), .cmd_valid(cmd_valid2), .cmd_code(cmd_code2), .err_cnt(err_cnt2)
`ifdef FCMD_TMR_EN
    , .tmr_err(tmr_err2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // ---------------- reference model ----------------
  localparam int M_HUNT = 0, M_ALIGN = 1, M_LOCKED = 2;
  bit   hist[$];          // bit sampled at each edge (0 on reset edges)
  int   t         = 0;    // index of the next edge
  int   rst_edge  = -1;
  int   m_mode    = M_HUNT;
  int   m_align_t = 0;
  int   m_idles   = 0;
  int   m_bad     = 0;
  logic exp_locked = 1'b0, exp_valid = 1'b0;
  int   exp_code = 0, exp_err = 0, exp_err2 = 0;
  logic exp_tmr = 1'b0;

  // Strobe bookkeeping
  int strobe_cnt = 0;
  int code4_cnt  = 0;
  int last_cyc [8];

  function automatic int code_of(input logic [7:0] w);
    case (w)
      8'h33:   return 1;
      8'h66:   return 2;
      8'h99:   return 3;
      8'hCC:   return 4;
      8'hA5:   return 5;
      default: return 0;
    endcase
  endfunction

  // The last 8 bits seen before edge e, newest bit in the LSB
  function automatic logic [7:0] word_at(input int e);
    logic [7:0] w;
    w = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      if (e - k >= 0 && e - k > rst_edge) w[k-1] = hist[e-k];
    end
    return w;
  endfunction

  task automatic model_step(input logic b, input logic clr, input logic rst);
    logic [7:0] w;
    int c;
    bit inc;
    w = word_at(t);
    c = code_of(w);
    inc = 1'b0;
    exp_valid = 1'b0;
    exp_code  = 0;
    if (rst) begin
      m_mode = M_HUNT; rst_edge = t; m_bad = 0; m_idles = 0;
      exp_err = 0; exp_err2 = 0;
    end else begin
      if (m_mode == M_HUNT) begin
        if (w == 8'h5A) begin
          m_mode = M_ALIGN; m_align_t = t; m_idles = 1;
        end
      end else if ((t - m_align_t) % 8 == 0) begin
        if (m_mode == M_ALIGN) begin
          if (w == 8'h5A) begin
            m_idles++;
            if (m_idles >= LOCK_CNT) begin m_mode = M_LOCKED; m_bad = 0; end
          end else begin
            m_mode = M_HUNT;
          end
        end else begin
          if (w == 8'h5A) begin
            m_bad = 0;
          end else if (c != 0) begin
            exp_valid = 1'b1; exp_code = c; m_bad = 0;
          end else begin
            inc = 1'b1;
            m_bad++;
            if (m_bad >= ERR_LIMIT) begin m_mode = M_HUNT; m_bad = 0; end
          end
        end
      end
      if (clr) begin
        exp_err = 0; exp_err2 = 0;
      end else if (inc) begin
        if (exp_err < 255) exp_err++;
        if (exp_err2 < 3) exp_err2++;
      end
    end
    exp_locked = (m_mode == M_LOCKED);
    hist.push_back(rst ? 1'b0 : b);
    t++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // One clock edge: drive inputs, advance the model, compare every output
  task automatic tick(input logic b, input logic clr, input logic rst);
    logic [31:0] got, want;
    fcmd_in = b; err_clr = clr; RST = rst;
    @(posedge clk);
    model_step(b, clr, rst);
    #1;
    got  = {12'd0, locked, cmd_valid, cmd_code, err_cnt, locked2, cmd_valid2, cmd_code2, err_cnt2};
    want = {12'd0, exp_locked, exp_valid, 3'(exp_code), 8'(exp_err),
            exp_locked, exp_valid, 3'(exp_code), 2'(exp_err2)};
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL model cyc %0d: got locked/valid/code/err/err2=%b/%b/%0d/%0d/%0d, want %b/%b/%0d/%0d/%0d",
               t, locked, cmd_valid, cmd_code, err_cnt, err_cnt2,
               exp_locked, exp_valid, exp_code, exp_err, exp_err2);
    end
`ifdef FCMD_TMR_EN
    compared++;
    if ({tmr_err, tmr_err2} !== {exp_tmr, 1'b0}) begin
      mismatched++;
      $display("FAIL tmr_err cyc %0d: got %b/%b, want %b/0", t, tmr_err, tmr_err2, exp_tmr);
    end
`endif
    if (cmd_valid === 1'b1) begin
      strobe_cnt++;
      last_cyc[cmd_code] = t;
      if (cmd_code == 3'd4) code4_cnt++;
    end
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int j = n - 1; j >= 0; j--) tick(w[j], 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w);
    send_bits(w, 8);
  endtask

  task automatic do_reset(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b1);
  endtask

  // Random-phase bit: occasional err_clr, rare reset
  task automatic rsend_bits(input logic [7:0] w, input int n);
    for (int j = n - 1; j >= 0; j--)
      tick(w[j], ($urandom_range(0, 39) == 0), ($urandom_range(0, 2999) == 0));
  endtask

  // ---------------- table of word vectors ----------------
  typedef struct {
    logic [7:0] word;    // word shifted in, MSB first
    logic       clr;     // err_clr on the edge after the word
    logic       lck;     // expected locked after that edge
    logic       vld;     // expected cmd_valid after that edge
    logic [2:0] code;    // expected cmd_code
    int         err;     // expected err_cnt (ERR_W=8 instance)
  } vec_t;

  vec_t vecs [22];
  logic [7:0] cmds [5];
  int r;
  int s0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h5A, 1'b0, 1'b0, 1'b0, 3'd0, 0};
    vecs[1]  = '{8'h5A, 1'b0, 1'b0, 1'b0, 3'd0, 0};
    vecs[2]  = '{8'h5A, 1'b0, 1'b0, 1'b0, 3'd0, 0};
    vecs[3]  = '{8'h5A, 1'b0, 1'b1, 1'b0, 3'd0, 0};  // 4th aligned IDLE: lock
    vecs[4]  = '{8'h5A, 1'b0, 1'b1, 1'b0, 3'd0, 0};
    vecs[5]  = '{8'h33, 1'b0, 1'b1, 1'b1, 3'd1, 0};  // BC0
    vecs[6]  = '{8'h5A, 1'b0, 1'b1, 1'b0, 3'd0, 0};
    vecs[7]  = '{8'h66, 1'b0, 1'b1, 1'b1, 3'd2, 0};  // RESYNC
    vecs[8]  = '{8'hA5, 1'b0, 1'b1, 1'b1, 3'd5, 0};  // DTU_SYNC
    vecs[9]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 1};
    vecs[10] = '{8'h5A, 1'b0, 1'b1, 1'b0, 3'd0, 1};  // IDLE resets the run
    vecs[11] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 2};
    vecs[12] = '{8'h01, 1'b0, 1'b1, 1'b0, 3'd0, 3};
    vecs[13] = '{8'h02, 1'b0, 1'b0, 1'b0, 3'd0, 4};  // 3rd in a row: lock lost
    vecs[14] = '{8'h5A, 1'b0, 1'b0, 1'b0, 3'd0, 4};
    vecs[15] = '{8'h5A, 1'b0, 1'b0, 1'b0, 3'd0, 4};
    vecs[16] = '{8'h5A, 1'b0, 1'b0, 1'b0, 3'd0, 4};
    vecs[17] = '{8'h5A, 1'b0, 1'b1, 1'b0, 3'd0, 4};  // relocked, count kept
    vecs[18] = '{8'h99, 1'b0, 1'b1, 1'b1, 3'd3, 4};
    vecs[19] = '{8'hCC, 1'b0, 1'b1, 1'b1, 3'd4, 4};
    vecs[20] = '{8'h7E, 1'b1, 1'b1, 1'b0, 3'd0, 0};  // clear wins over increment
    vecs[21] = '{8'h5A, 1'b0, 1'b1, 1'b0, 3'd0, 0};
    cmds = '{8'h33, 8'h66, 8'h99, 8'hCC, 8'hA5};
    for (int k = 0; k < 8; k++) last_cyc[k] = 0;

    RST = 1'b1; fcmd_in = 1'b0; err_clr = 1'b0;

    // Reset state
    do_reset(3);
    check("reset_outputs", {locked, cmd_valid, cmd_code, err_cnt, err_cnt2}, 32'd0);

    // Table: 13 zero bits, then the word vectors, checked one edge after each word
    repeat (13) tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      for (int j = 7; j >= 0; j--) begin
        tick(vecs[i].word[j], (j == 7 && i > 0) ? vecs[(i > 0) ? i - 1 : 0].clr : 1'b0, 1'b0);
        if (j == 7 && i > 0)
          check($sformatf("vec%0d_word%02h", i - 1, vecs[i-1].word),
                {locked, cmd_valid, cmd_code, err_cnt},
                {19'd0, vecs[i-1].lck, vecs[i-1].vld, vecs[i-1].code, 8'(vecs[i-1].err)});
      end
    end
    tick(1'b0, vecs[21].clr, 1'b0);
    check("vec21_word5a", {locked, cmd_valid, cmd_code, err_cnt},
          {19'd0, vecs[21].lck, vecs[21].vld, vecs[21].code, 8'(vecs[21].err)});
    check("bc0_to_resync_spacing", 32'(last_cyc[2] - last_cyc[1]), 32'd16);

    // Lock-up from random leading bits
    do_reset(2);
    for (int k = 0; k < 13; k++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    s0 = strobe_cnt;
    repeat (5) send_word(8'h5A);
    tick(1'b0, 1'b0, 1'b0);
    check("lockup_locked", {31'd0, locked}, 32'd1);
    check("lockup_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // Saturation with ERR_W=2 while losing and regaining lock
    do_reset(2);
    repeat (2) begin
      repeat (4) send_word(8'h5A);
      send_word(8'hFF); send_word(8'h00); send_word(8'h01);
    end
    tick(1'b0, 1'b0, 1'b0);
    check("sat_err8", {24'd0, err_cnt}, 32'd6);
    check("sat_err2_held", {30'd0, err_cnt2}, 32'd3);
    send_bits(8'h5A, 7);
    repeat (4) send_word(8'h5A);
    send_word(8'h02);
    tick(1'b0, 1'b1, 1'b0);             // err_clr on the increment edge
    check("clr_vs_inc", {22'd0, err_cnt, err_cnt2}, 32'd0);
    send_bits(8'h5A, 7);

    // Alignment reject: ALIGN sees TEST_PULSE instead of IDLE
    do_reset(2);
    s0 = strobe_cnt;
    send_word(8'h5A);
    send_word(8'h99);
    tick(1'b0, 1'b0, 1'b0);
    check("align_reject_locked", {31'd0, locked}, 32'd0);
    send_bits(8'h5A, 7);
    send_word(8'h5A);
    send_word(8'h5A);
    tick(1'b0, 1'b0, 1'b0);
    check("align_rehunt_3idle", {31'd0, locked}, 32'd0);
    send_bits(8'h5A, 7);
    tick(1'b0, 1'b0, 1'b0);
    check("align_relock_4idle", {31'd0, locked}, 32'd1);
    check("align_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    send_bits(8'h5A, 7);

    // Reset three bits into an ADC_CAL word while locked
    repeat (2) send_word(8'h5A);
    send_word(8'hFF);
    send_word(8'h5A);
    check("pre_reset_err", {24'd0, err_cnt}, 32'd1);
    s0 = code4_cnt;
    send_bits(8'h06, 3);                // 3'b110: top bits of 8'hCC
    tick(1'b1, 1'b0, 1'b1);
    check("reset_mid_word", {20'd0, locked, cmd_valid, cmd_code, err_cnt}, 32'd0);
    send_bits(8'h0C, 4);                // remaining 4'b1100
    repeat (16) tick(1'b0, 1'b0, 1'b0);
    check("reset_no_code4", 32'(code4_cnt - s0), 32'd0);

`ifdef FCMD_TMR_EN
    // Upset one copy between edges; voted outputs must not move
    repeat (5) send_word(8'h5A);
    force dut.g_copy[1].st_reg = '0;
    #2;
    release dut.g_copy[1].st_reg;
    exp_tmr = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    exp_tmr = 1'b0;
    check("tmr_locked_kept", {31'd0, locked}, 32'd1);
    tick(1'b1, 1'b0, 1'b0);
    send_bits(8'h5A, 6);
`endif

    // Randomized traffic against the model
    do_reset(2);
    for (int n = 0; n < 350; n++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        repeat ($urandom_range(3, 6)) rsend_bits(8'h5A, 8);
      end else if (r < 55) begin
        rsend_bits(cmds[$urandom_range(0, 4)], 8);
      end else if (r < 75) begin
        rsend_bits(8'($urandom), 8);
      end else if (r < 88) begin
        rsend_bits(8'h5A, 8);
      end else begin
        rsend_bits(8'($urandom), $urandom_range(1, 7));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
